mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_resp_pkg.sv | 28 ++
 rtl/mem_lane_align.sv | 44 ++++
 rtl/mem_responder.sv | 110 +++++++++++
 tb/tb_mem_responder.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_resp_pkg.sv
// Shared definitions for the memory responder: access size codes,
// FSM state encoding and the alignment/legality helper.
package mem_resp_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // True when the size code is illegal or the address is not naturally
  // aligned for that size.
  function automatic logic size_fault(input logic [1:0] size, input logic [1:0] lo);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = lo[0];
      SZ_WORD: bad = (lo != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for the memory responder: merges store data into the
// addressed lanes of a word and extracts/extends load data from a word.
module mem_lane_align
  import mem_resp_pkg::*;
(
  input  logic [31:0] word_in,
  input  logic [1:0]  lane,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  output logic [31:0] merged,
  output logic [31:0] load_data
);

  logic [31:0] shifted;

  // Shift the addressed lane down to bit 0, then merge or extend per size.
  always_comb begin
    shifted   = word_in >> {lane, 3'b000};
    merged    = word_in;
    load_data = '0;
    case (size)
      SZ_BYTE: begin
        merged[{lane, 3'b000} +: 8] = wdata[7:0];
        load_data = is_unsigned ? {24'd0, shifted[7:0]}
                                : {{24{shifted[7]}}, shifted[7:0]};
      end
      SZ_HALF: begin
        merged[{lane[1], 4'b0000} +: 16] = wdata[15:0];
        load_data = is_unsigned ? {16'd0, shifted[15:0]}
                                : {{16{shifted[15]}}, shifted[15:0]};
      end
      SZ_WORD: begin
        merged    = wdata;
        load_data = word_in;
      end
      default: begin
        merged    = word_in;
        load_data = '0;
      end
    endcase
  end

endmodule

// File: rtl/mem_responder.sv
// Single-outstanding memory responder: accepts one load/store, waits a fixed
// number of cycles, then presents the response until the initiator takes it.
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int          AW         = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [32:0] BYTE_LIMIT = 33'(DEPTH_WORDS) << 2;
  localparam logic [3:0]  CNT_INIT   = 4'(LATENCY - 1);

  state_t        state, state_next;
  logic [3:0]    cnt;
  logic          lat_we, lat_unsigned;
  logic [31:0]   lat_addr, lat_wdata;
  logic [1:0]    lat_size;
  logic          accept, fire, req_bad;
  logic [AW-1:0] word_idx;
  logic [31:0]   mem [DEPTH_WORDS];
  logic [31:0]   cur_word, merged_word, load_word;

  assign word_idx = lat_addr[AW+1:2];
  assign cur_word = mem[word_idx];
  assign req_bad  = size_fault(lat_size, lat_addr[1:0]) || ({1'b0, lat_addr} >= BYTE_LIMIT);

  mem_lane_align u_align (
    .word_in    (cur_word),
    .lane       (lat_addr[1:0]),
    .size       (lat_size),
    .is_unsigned(lat_unsigned),
    .wdata      (lat_wdata),
    .merged     (merged_word),
    .load_data  (load_word)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // Next state: the counter runs even for LATENCY=1 so the response always
  // trails the accept edge by exactly LATENCY cycles.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = WAIT;
      WAIT:    if (cnt == 4'd0) state_next = RESP;
      RESP:    if (resp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM outputs and handshake strobes; nothing is accepted while in reset.
  always_comb begin
    req_ready  = rst && (state == IDLE);
    accept     = req_valid && req_ready;
    resp_valid = (state == RESP);
    fire       = (state == WAIT) && (cnt == 4'd0);
  end

  // Capture the accepted request and run the latency counter.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= 4'd0;
    end else if (accept) begin
      lat_we       <= req_we;
      lat_addr     <= req_addr;
      lat_size     <= req_size;
      lat_unsigned <= req_unsigned;
      lat_wdata    <= req_wdata;
      cnt          <= CNT_INIT;
    end else if (state == WAIT && cnt != 4'd0) begin
      cnt <= cnt - 4'd1;
    end
  end

  // Response registers, loaded on entry to RESP and held until consumed.
  always_ff @(posedge clk) begin
    if (!rst) begin
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else if (fire) begin
      resp_err   <= req_bad;
      resp_rdata <= (req_bad || lat_we) ? 32'd0 : load_word;
    end
  end

  // Storage: legal stores commit on entry to RESP; reset leaves it intact.
  always_ff @(posedge clk) begin
    if (rst && fire && lat_we && !req_bad) mem[word_idx] <= merged_word;
  end

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder with a byte-array reference model.
module tb_mem_responder;

  localparam int DEPTH = 256;
  localparam int LAT   = 2;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0, req_ready, req_we = 1'b0, req_unsigned = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [1:0]  req_size = '0;
  logic        resp_valid, resp_ready = 1'b0, resp_err;
  logic [31:0] resp_rdata;

  logic        l1_req_valid = 1'b0, l1_req_ready, l1_req_we = 1'b0, l1_req_unsigned = 1'b0;
  logic [31:0] l1_req_addr = '0, l1_req_wdata = '0;
  logic [1:0]  l1_req_size = '0;
  logic        l1_resp_valid, l1_resp_err;
  logic        l1_resp_ready = 1'b1;
  logic [31:0] l1_resp_rdata;

  int          checks = 0;
  int          failures = 0;
  int          cycle = 0;
  int          stall_cnt = 0;
  exp_t        sb_q[$];
  logic [7:0]  model_mem [DEPTH*4];

  logic        prev_valid = 1'b0, hs_pending = 1'b0, hold_err = 1'b0;
  logic [31:0] hold_rdata = '0;

  mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst),
    .req_valid(l1_req_valid), .req_ready(l1_req_ready), .req_we(l1_req_we),
    .req_addr(l1_req_addr), .req_size(l1_req_size), .req_unsigned(l1_req_unsigned),
    .req_wdata(l1_req_wdata),
    .resp_valid(l1_resp_valid), .resp_ready(l1_resp_ready),
    .resp_rdata(l1_resp_rdata), .resp_err(l1_resp_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // Reference model: byte-addressed little-endian memory with the legality rules.
  function automatic void modelAccess(input logic we, input logic [31:0] addr, input logic [1:0] size,
                                      input logic uns, input logic [31:0] wdata,
                                      output logic [31:0] rdata, output logic err);
    int n;
    int bits;
    logic [63:0] v;
    n = 1 << size;
    err = (size == 2'b11) || (size == 2'b01 && addr[0]) || (size == 2'b10 && addr[1:0] != 2'b00) ||
          (addr >= 32'(DEPTH * 4));
    rdata = 32'd0;
    if (!err) begin
      if (we) begin
        for (int i = 0; i < n; i++) model_mem[int'(addr) + i] = wdata[8*i +: 8];
      end else begin
        v = 64'd0;
        for (int i = 0; i < n; i++) v = v | (64'(model_mem[int'(addr) + i]) << (8 * i));
        bits = 8 * n;
        if (!uns && v[bits-1]) v = v - (64'd1 << bits);
        rdata = v[31:0];
      end
    end
  endfunction

  // Issue one request, queue its expected response, and scramble req_* while busy.
  task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [1:0] size,
                               input logic uns, input logic [31:0] wdata, input int stall);
    exp_t e;
    int   guard;
    guard = 0;
    @(negedge clk); #1;
    while (!req_ready && guard < 200) begin
      @(negedge clk); #1;
      guard++;
    end
    if (!req_ready) begin
      checkOutput("ready_timeout", 32'(req_ready), 32'd1);
      return;
    end
    modelAccess(we, addr, size, uns, wdata, e.rdata, e.err);
    e.acc = cycle;
    sb_q.push_back(e);
    stall_cnt    = stall;
    req_valid    = 1'b1;
    req_we       = we;
    req_addr     = addr;
    req_size     = size;
    req_unsigned = uns;
    req_wdata    = wdata;
    @(posedge clk);
    guard = 0;
    forever begin
      @(negedge clk); #1;
      if ((resp_valid && resp_ready) || guard >= 100) break;
      req_valid    = 1'b1;
      req_we       = 1'($urandom);
      req_addr     = $urandom;
      req_size     = 2'($urandom);
      req_unsigned = 1'($urandom);
      req_wdata    = $urandom;
      guard++;
    end
    req_valid = 1'b0;
    if (guard >= 100) checkOutput("resp_timeout", 32'(resp_valid && resp_ready), 32'd1);
  endtask

  // Monitor and response-side driver: pops the scoreboard on each new response.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      prev_valid = 1'b0;
      hs_pending = 1'b0;
      resp_ready = 1'b0;
    end else begin
      if (hs_pending) begin
        checkOutput("ready_after_resp", 32'(req_ready), 32'd1);
        checkOutput("valid_dropped", 32'(resp_valid), 32'd0);
        hs_pending = 1'b0;
      end
      if (resp_valid) begin
        checkOutput("ready_low_in_resp", 32'(req_ready), 32'd0);
        if (!prev_valid) begin
          if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL unexpected_resp: got rdata 0x%08h err %0b with no request outstanding",
                     resp_rdata, resp_err);
          end else begin
            e = sb_q.pop_front();
            checkOutput("rdata", resp_rdata, e.rdata);
            checkOutput("err", 32'(resp_err), 32'(e.err));
            checkOutput("accept_to_valid", 32'(cycle - e.acc), 32'(LAT + 1));
          end
          hold_rdata = resp_rdata;
          hold_err   = resp_err;
        end else begin
          checkOutput("rdata_stable", resp_rdata, hold_rdata);
          checkOutput("err_stable", 32'(resp_err), 32'(hold_err));
        end
        if (stall_cnt > 0) begin
          resp_ready = 1'b0;
          stall_cnt--;
        end else begin
          resp_ready = 1'b1;
          hs_pending = 1'b1;
        end
      end else begin
        resp_ready = 1'b0;
      end
      prev_valid = resp_valid;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int guard;
    logic [31:0] a;
    int r;

    // Reset behaviour.
    repeat (3) begin
      @(negedge clk);
      checkOutput("rst_req_ready", 32'(req_ready), 32'd0);
      checkOutput("rst_resp_valid", 32'(resp_valid), 32'd0);
      checkOutput("rst_rdata", resp_rdata, 32'd0);
      checkOutput("rst_err", 32'(resp_err), 32'd0);
    end
    rst = 1'b1;
    #1;
    checkOutput("ready_after_release", 32'(req_ready), 32'd1);

    // Preload the low 128 bytes so every later load has a known value.
    for (int w = 0; w < 32; w++) applyStimulus(1'b1, 32'(w * 4), 2'b10, 1'b0, $urandom, 0);

    // Word store/load round trip.
    applyStimulus(1'b1, 32'h10, 2'b10, 1'b0, 32'hDEADBEEF, 0);
    applyStimulus(1'b0, 32'h10, 2'b10, 1'b0, 32'h0, 0);

    // Byte store and sign/zero-extended byte loads.
    applyStimulus(1'b1, 32'h13, 2'b00, 1'b0, 32'h00000080, 1);
    applyStimulus(1'b0, 32'h13, 2'b00, 1'b0, 32'h0, 0);
    applyStimulus(1'b0, 32'h13, 2'b00, 1'b1, 32'h0, 2);
    applyStimulus(1'b0, 32'h10, 2'b10, 1'b0, 32'h0, 0);

    // Error cases, then confirm storage untouched.
    applyStimulus(1'b0, 32'h11, 2'b01, 1'b0, 32'h0, 0);
    applyStimulus(1'b0, 32'h12, 2'b10, 1'b0, 32'h0, 0);
    applyStimulus(1'b0, 32'h10, 2'b11, 1'b0, 32'h0, 0);
    applyStimulus(1'b0, 32'h400, 2'b10, 1'b0, 32'h0, 0);
    applyStimulus(1'b1, 32'h12, 2'b10, 1'b0, 32'h11223344, 0);
    applyStimulus(1'b1, 32'h400, 2'b10, 1'b0, 32'h55667788, 0);
    applyStimulus(1'b0, 32'h10, 2'b10, 1'b0, 32'h0, 0);

    // Long stall in RESP.
    applyStimulus(1'b0, 32'h10, 2'b10, 1'b0, 32'h0, 5);

    // Reset while a store to 0x20 sits in WAIT: it must be dropped.
    @(negedge clk); #1;
    guard = 0;
    while (!req_ready && guard < 50) begin
      @(negedge clk); #1;
      guard++;
    end
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_size = 2'b10;
    req_unsigned = 1'b0; req_wdata = 32'h12345678;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    rst = 1'b0;
    repeat (2) begin
      @(negedge clk);
      checkOutput("rst_wait_req_ready", 32'(req_ready), 32'd0);
      checkOutput("rst_wait_resp_valid", 32'(resp_valid), 32'd0);
    end
    rst = 1'b1;
    #1;
    checkOutput("ready_after_rst_wait", 32'(req_ready), 32'd1);
    repeat (4) begin
      @(negedge clk);
      checkOutput("no_resp_after_drop", 32'(resp_valid), 32'd0);
    end
    applyStimulus(1'b0, 32'h20, 2'b10, 1'b0, 32'h0, 0);

    // Randomised traffic, mostly inside the preloaded region.
    for (int t = 0; t < 60; t++) begin
      r = $urandom_range(0, 9);
      if (r == 0)      a = 32'h400 + 32'($urandom_range(0, 15));
      else if (r == 1) a = $urandom | 32'h0000_1000;
      else             a = 32'($urandom_range(0, 127));
      applyStimulus(1'($urandom), a, 2'($urandom), 1'($urandom), $urandom, $urandom_range(0, 3));
    end

    // LATENCY=1 instance: response appears one cycle after the accept edge.
    @(negedge clk);
    checkOutput("l1_ready", 32'(l1_req_ready), 32'd1);
    l1_req_valid = 1'b1; l1_req_we = 1'b1; l1_req_addr = 32'h8; l1_req_size = 2'b10;
    l1_req_wdata = 32'hA5A55A5A;
    @(posedge clk);
    @(negedge clk);
    l1_req_valid = 1'b0;
    checkOutput("l1_store_not_early", 32'(l1_resp_valid), 32'd0);
    @(negedge clk);
    checkOutput("l1_store_valid", 32'(l1_resp_valid), 32'd1);
    checkOutput("l1_store_err", 32'(l1_resp_err), 32'd0);
    @(negedge clk);
    checkOutput("l1_ready_again", 32'(l1_req_ready), 32'd1);
    l1_req_valid = 1'b1; l1_req_we = 1'b0;
    @(posedge clk);
    @(negedge clk);
    l1_req_valid = 1'b0;
    checkOutput("l1_load_not_early", 32'(l1_resp_valid), 32'd0);
    @(negedge clk);
    checkOutput("l1_load_valid", 32'(l1_resp_valid), 32'd1);
    checkOutput("l1_load_rdata", l1_resp_rdata, 32'hA5A55A5A);

    // Drain the scoreboard.
    guard = 0;
    while (sb_q.size() != 0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    repeat (3) @(negedge clk);
    checkOutput("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
